// File: rtl/miinst_issue_queue_pkg.sv
// Shared types for the micro-instruction issue queue: slot format, opcodes,
// bundle width and the system default queue depth.
package miinst_issue_queue_pkg;

    localparam int MQ_N      = 4;
    localparam int MIQ_DEPTH = 16;
    localparam int MQ_KW     = $clog2(MQ_N) + 1;

    typedef enum logic [3:0] {
        MIOP_NOP      = 4'd0,
        MIOP_POP_LOAD = 4'd1,
        MIOP_ADDI     = 4'd2,
        MIOP_MOVI     = 4'd3,
        MIOP_STORE    = 4'd4,
        MIOP_ALU      = 4'd5,
        MIOP_BRANCH   = 4'd6
    } miop_e;

    typedef struct packed {
        miop_e       op;
        logic [3:0]  rd;
        logic [7:0]  imm;
    } miinst_t;

    function automatic logic is_nop(input miinst_t mi);
        return mi.op == MIOP_NOP;
    endfunction

endpackage

// File: rtl/miinst_compactor.sv
// Drops NOP slots from a decode bundle and packs the survivors, in slot order,
// into the low indices; k is the number of surviving slots.
module miinst_compactor
    import miinst_issue_queue_pkg::*;
(
    input  miinst_t          in_miinst [MQ_N],
    output miinst_t          dense     [MQ_N],
    output logic [MQ_KW-1:0] k
);

    always_comb begin
        // NOTE: blocking assignments in combinational logic, and every output
        // gets a default first so no latch is inferred.
        for (int i = 0; i < MQ_N; i++) begin
            dense[i] = '0;
        end
        k = '0;
        for (int i = 0; i < MQ_N; i++) begin
            if (!is_nop(in_miinst[i])) begin
                dense[k[MQ_KW-2:0]] = in_miinst[i];
                k = k + MQ_KW'(1);
            end
        end
    end

endmodule

// File: rtl/miinst_issue_queue.sv
// Circular issue queue: accepts a compacted decode bundle per cycle and
// issues one micro-instruction per cycle to execute.
module miinst_issue_queue
    import miinst_issue_queue_pkg::*;
#(
    parameter int DEPTH = MIQ_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    input  miinst_t       in_miinst [MQ_N],
    output logic          in_ready,
    input  logic          flush,
    output logic          out_valid,
    output miinst_t       out_miinst,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    miinst_t          mem   [DEPTH];
    miinst_t          dense [MQ_N];
    logic [MQ_KW-1:0] k;
    logic             enq;
    logic             deq;

    miinst_compactor u_compactor (
        .in_miinst (in_miinst),
        .dense     (dense),
        .k         (k)
    );

    // Room for a whole bundle regardless of its NOP count; same-cycle dequeue gives no credit.
    assign in_ready   = count <= CW'(DEPTH - MQ_N);
    assign out_valid  = count != '0;
    assign out_miinst = out_valid ? mem[head] : '0;
    assign enq        = in_valid & in_ready & ~flush;
    assign deq        = out_valid & out_ready & ~flush;

    // NOTE: storage has no reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int j = 0; j < MQ_N; j++) begin
                if (MQ_KW'(j) < k) begin
                    mem[tail + PW'(j)] <= dense[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(k);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            count <= count + (enq ? CW'(k) : CW'(0)) - CW'(deq);
        end
    end

endmodule

// File: tb/tb_miinst_issue_queue.sv
// Self-checking bench for miinst_issue_queue: a queue-based reference model
// compared every cycle, directed scenarios with literal expectations, and a random soak.
module tb_miinst_issue_queue;
    import miinst_issue_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b1;
    logic          in_valid  = 1'b0;
    logic          flush     = 1'b0;
    logic          out_ready = 1'b0;
    miinst_t       in_miinst [MQ_N];
    logic          in_ready;
    logic          out_valid;
    miinst_t       out_miinst;
    logic [CW-1:0] count;

    int      n_checks = 0;
    int      n_fail   = 0;
    miinst_t model_q[$];
    miinst_t w[4];
    bit      hold;
    bit      accept;
    int      nop_pct;
    int      rdy_pct;

    miinst_issue_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_miinst  (in_miinst),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_miinst (out_miinst),
        .out_ready  (out_ready),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic miinst_t mk(input miop_e op, input int rd, input int imm);
        miinst_t m;
        m.op  = op;
        m.rd  = 4'(rd);
        m.imm = 8'(imm);
        return m;
    endfunction

    function automatic miinst_t rand_slot(input int nop_percent);
        if ($urandom_range(0, 99) < nop_percent)
            return mk(MIOP_NOP, $urandom_range(0, 15), $urandom_range(0, 255));
        return mk(miop_e'(4'($urandom_range(1, 6))), $urandom_range(0, 15), $urandom_range(0, 255));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input miinst_t a, input miinst_t b, input miinst_t c, input miinst_t d);
        in_miinst[0] = a;
        in_miinst[1] = b;
        in_miinst[2] = c;
        in_miinst[3] = d;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!out_valid) break;
            cycle();
        end
        check("drain_done", out_valid, 0);
    endtask

    // Reference model: a FIFO of the non-NOP slots of every accepted bundle.
    always @(posedge clk or negedge rstn) begin
        bit acc;
        if (!rstn || flush) begin
            model_q.delete();
        end else begin
            acc = in_valid && (DEPTH - model_q.size() >= MQ_N);
            if (model_q.size() != 0 && out_ready) void'(model_q.pop_front());
            if (acc) begin
                for (int i = 0; i < MQ_N; i++) begin
                    if (in_miinst[i].op != MIOP_NOP) model_q.push_back(in_miinst[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        miinst_t exp_mi;
        exp_mi = (model_q.size() != 0) ? model_q[0] : '0;
        check("count", 32'(count), model_q.size());
        check("out_valid", out_valid, model_q.size() != 0);
        check("in_ready", in_ready, (DEPTH - model_q.size()) >= MQ_N);
        check("out_miinst", out_miinst, exp_mi);
        check("count_max", count <= CW'(DEPTH), 1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        set_bundle('0, '0, '0, '0);
        #1 rstn = 1'b0;
        #10 rstn = 1'b1;
        cycle();
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);

        // Two live slots followed by NOPs.
        set_bundle(mk(MIOP_POP_LOAD, 1, 8'h10), mk(MIOP_ADDI, 2, 8'h20), mk(MIOP_NOP, 0, 0), mk(MIOP_NOP, 0, 0));
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("b1_count", 32'(count), 2);
        check("b1_first", out_miinst, mk(MIOP_POP_LOAD, 1, 8'h10));
        out_ready = 1'b1;
        cycle();
        check("b1_second", out_miinst, mk(MIOP_ADDI, 2, 8'h20));
        cycle();
        check("b1_empty", out_valid, 0);
        out_ready = 1'b0;

        // NOPs interleaved with live slots.
        set_bundle(mk(MIOP_NOP, 3, 3), mk(MIOP_MOVI, 4, 8'h44), mk(MIOP_NOP, 5, 5), mk(MIOP_STORE, 6, 8'h66));
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("b2_count", 32'(count), 2);
        check("b2_first", out_miinst, mk(MIOP_MOVI, 4, 8'h44));
        out_ready = 1'b1;
        cycle();
        check("b2_second", out_miinst, mk(MIOP_STORE, 6, 8'h66));
        cycle();
        out_ready = 1'b0;

        // Fill to capacity, hold a third bundle until credit returns.
        set_bundle(mk(MIOP_ALU, 1, 1), mk(MIOP_ALU, 2, 2), mk(MIOP_ALU, 3, 3), mk(MIOP_ALU, 4, 4));
        in_valid = 1'b1;
        cycle();
        check("fill_count4", 32'(count), 4);
        check("fill_ready4", in_ready, 1);
        set_bundle(mk(MIOP_ADDI, 5, 5), mk(MIOP_ADDI, 6, 6), mk(MIOP_ADDI, 7, 7), mk(MIOP_ADDI, 8, 8));
        cycle();
        check("fill_count8", 32'(count), 8);
        check("fill_ready8", in_ready, 0);
        set_bundle(mk(MIOP_MOVI, 9, 9), mk(MIOP_MOVI, 10, 10), mk(MIOP_MOVI, 11, 11), mk(MIOP_MOVI, 12, 12));
        cycle();
        cycle();
        check("held_count", 32'(count), 8);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("held_drain", 32'(count), 32'(7 - i));
        end
        check("held_ready", in_ready, 1);
        cycle();
        in_valid = 1'b0;
        check("held_accept", 32'(count), 7);
        drain();

        // Move the pointers to 6, then enqueue across the wrap.
        set_bundle(mk(MIOP_ALU, 0, 0), mk(MIOP_ALU, 0, 1), mk(MIOP_ALU, 0, 2), mk(MIOP_ALU, 0, 3));
        in_valid = 1'b1;
        cycle();
        set_bundle(mk(MIOP_ALU, 0, 4), mk(MIOP_NOP, 0, 0), mk(MIOP_ALU, 0, 5), mk(MIOP_NOP, 0, 0));
        cycle();
        drain();
        out_ready = 1'b0;
        w[0] = mk(MIOP_POP_LOAD, 1, 8'hA0);
        w[1] = mk(MIOP_ADDI, 2, 8'hA1);
        w[2] = mk(MIOP_MOVI, 3, 8'hA2);
        w[3] = mk(MIOP_STORE, 4, 8'hA3);
        set_bundle(w[0], w[1], w[2], w[3]);
        in_valid = 1'b1;
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("wrap_order", out_miinst, w[i]);
            cycle();
        end
        check("wrap_empty", out_valid, 0);
        out_ready = 1'b0;

        // Flush at count 5 with a bundle and a dequeue in the same cycle.
        set_bundle(mk(MIOP_ALU, 7, 1), mk(MIOP_ALU, 7, 2), mk(MIOP_ALU, 7, 3), mk(MIOP_ALU, 7, 4));
        in_valid = 1'b1;
        cycle();
        set_bundle(mk(MIOP_NOP, 0, 0), mk(MIOP_NOP, 0, 0), mk(MIOP_BRANCH, 7, 5), mk(MIOP_NOP, 0, 0));
        cycle();
        check("pre_flush_count", 32'(count), 5);
        check("pre_flush_ready", in_ready, 0);
        flush     = 1'b1;
        out_ready = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_valid", out_valid, 0);
        check("flush_out", out_miinst, 0);
        cycle();
        check("flush_quiet", out_valid, 0);

        // Flush while in_ready is high: the offered bundle is discarded.
        out_ready = 1'b0;
        set_bundle(mk(MIOP_STORE, 8, 1), mk(MIOP_STORE, 8, 2), mk(MIOP_STORE, 8, 3), mk(MIOP_STORE, 8, 4));
        in_valid = 1'b1;
        cycle();
        flush = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush2_count", 32'(count), 0);
        cycle();
        check("flush2_quiet", out_valid, 0);

        // Asynchronous reset mid-burst.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_bundle(rand_slot(0), rand_slot(0), rand_slot(0), rand_slot(0));
            cycle();
        end
        #2 rstn = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_count", 32'(count), 0);
        check("arst_ready", in_ready, 1);
        check("arst_out", out_miinst, 0);
        in_valid = 1'b0;
        #10 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("arst_no_stale", out_valid, 0);
        end

        // Random soak with the hold rule honoured by the stimulus.
        hold = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            nop_pct = (c / 1000) * 10;
            rdy_pct = ((c / 500) % 2 == 1) ? 30 : 85;
            if (!hold) begin
                in_valid = $urandom_range(0, 1) == 1;
                set_bundle(rand_slot(nop_pct), rand_slot(nop_pct), rand_slot(nop_pct), rand_slot(nop_pct));
            end
            out_ready = $urandom_range(0, 99) < rdy_pct;
            flush     = $urandom_range(0, 63) == 0;
            accept    = in_valid && (DEPTH - model_q.size() >= MQ_N);
            hold      = in_valid && !accept && !flush;
            cycle();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
